// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared types, limits and helpers for the gate truth-table reader
// Purpose: sweep FSM state encoding, legal parameter limits, table-width helper.
// Ports: none (package).
package gate_tt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MAX = 15;

    // Number of truth-table entries for n gate inputs.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// rtl/gate_tt_settle_cnt.sv - per-vector settle counter with terminal flag
// Purpose: counts cycles a vector has been held; term flags count==SETTLE.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear count to zero (wins over inc)
//   inc      : increment count
//   term     : count has reached SETTLE
module gate_tt_settle_cnt
    import gate_tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam int CW = $clog2(SETTLE_MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CW'(SETTLE));

endmodule

// File: rtl/gate_tt_reader.sv
// rtl/gate_tt_reader.sv - drives every input combination into a gate and captures its truth table
// Purpose: on start, steps drv through 0..2**N_IN-1 holding each SETTLE+1 cycles,
//   samples sense at the end of each hold, then publishes table_o/match with a done pulse.
// Optional feature macro: GATE_TT_FIRST_FAIL_EN (adds first_fail_vld/first_fail_idx).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : sweep request, accepted only while idle
//   expected  : reference table, sampled at the completion edge
//   sense     : gate output under test
//   drv       : gate input vector
//   busy      : sweep in progress
//   done      : one-cycle completion pulse
//   table_o   : captured truth table (updated at completion only)
//   match     : table_o == expected, registered at completion
//   first_fail_vld/first_fail_idx : lowest mismatching entry (feature only)
module gate_tt_reader
    import gate_tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [tt_width(N_IN)-1:0] expected,
    input  logic                      sense,
    output logic [N_IN-1:0]           drv,
    output logic                      busy,
    output logic                      done,
    output logic [tt_width(N_IN)-1:0] table_o,
    output logic                      match
`ifdef GATE_TT_FIRST_FAIL_EN
    ,
    output logic                      first_fail_vld,
    output logic [N_IN-1:0]           first_fail_idx
`endif
);

    localparam int TT = tt_width(N_IN);
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(TT - 1);

    state_t         state, next_state;
    logic [N_IN:0]  index;
    logic [TT-1:0]  shadow;
    logic [TT-1:0]  merged;
    logic           cnt_clr, cnt_inc, cnt_term;
    logic           launch, step, finish;

    gate_tt_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .term (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        launch     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    launch     = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_term) begin
                    cnt_clr = 1'b1;
                    if (index == LAST) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow table with the current sample folded in; used both for the
    // per-vector capture and for the final publish so the last bit is included.
    always_comb begin
        merged = shadow;
        merged[index[N_IN-1:0]] = sense;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index   <= '0;
            shadow  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            table_o <= '0;
            match   <= 1'b0;
        end else begin
            done <= finish;
            if (launch) begin
                busy   <= 1'b1;
                index  <= '0;
                shadow <= '0;
            end
            if (step) begin
                shadow <= merged;
                index  <= index + 1'b1;
            end
            if (finish) begin
                busy    <= 1'b0;
                index   <= '0;
                shadow  <= merged;
                table_o <= merged;
                match   <= (merged == expected);
            end
        end
    end

    assign drv = index[N_IN-1:0];

`ifdef GATE_TT_FIRST_FAIL_EN
    logic [TT-1:0]   diff;
    logic            ff_vld_nxt;
    logic [N_IN-1:0] ff_idx_nxt;

    // Scan downward so the lowest mismatching index is the one left standing.
    always_comb begin
        diff       = merged ^ expected;
        ff_vld_nxt = 1'b0;
        ff_idx_nxt = '0;
        for (int i = TT - 1; i >= 0; i--) begin
            if (diff[i]) begin
                ff_vld_nxt = 1'b1;
                ff_idx_nxt = i[N_IN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (finish) begin
            first_fail_vld <= ff_vld_nxt;
            first_fail_idx <= ff_idx_nxt;
        end
    end
`else
    // No first-fail tracking in this build.
`endif

endmodule

// File: tb/tb_gate_tt_reader.sv
// tb/tb_gate_tt_reader.sv - scoreboard bench for gate_tt_reader with OR gates under test
module tb_gate_tt_reader;

    typedef struct packed {
        logic [3:0] tbl;
        logic       m;
        logic       fv;
        logic [1:0] fi;
    } exp_t;

    logic       clk, rst;
    logic       start, start0;
    logic [3:0] expected, expected0;
    logic [1:0] drv, drv0;
    logic       busy, busy0, done, done0, match, match0;
    logic [3:0] table_o, table0;
    logic       sense, sense0;
`ifdef GATE_TT_FIRST_FAIL_EN
    logic       ffv, ffv0;
    logic [1:0] ffi, ffi0;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t q0[$];
    exp_t em, em0;

    // OR gates under test
    assign sense  = drv[1] | drv[0];
    assign sense0 = drv0[1] | drv0[0];

    gate_tt_reader #(.N_IN(2), .SETTLE(2)) dut (
        .clk (clk), .rst (rst), .start (start), .expected (expected), .sense (sense),
        .drv (drv), .busy (busy), .done (done), .table_o (table_o), .match (match)
`ifdef GATE_TT_FIRST_FAIL_EN
        , .first_fail_vld (ffv), .first_fail_idx (ffi)
`endif
    );

    gate_tt_reader #(.N_IN(2), .SETTLE(0)) dut0 (
        .clk (clk), .rst (rst), .start (start0), .expected (expected0), .sense (sense0),
        .drv (drv0), .busy (busy0), .done (done0), .table_o (table0), .match (match0)
`ifdef GATE_TT_FIRST_FAIL_EN
        , .first_fail_vld (ffv0), .first_fail_idx (ffi0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("done_was_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                em = q.pop_front();
                chk("table_o", 32'(table_o), 32'(em.tbl));
                chk("match", 32'(match), 32'(em.m));
`ifdef GATE_TT_FIRST_FAIL_EN
                chk("first_fail_vld", 32'(ffv), 32'(em.fv));
                chk("first_fail_idx", 32'(ffi), 32'(em.fi));
`endif
            end
        end
        if (done0) begin
            chk("done0_was_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                em0 = q0.pop_front();
                chk("table0", 32'(table0), 32'(em0.tbl));
                chk("match0", 32'(match0), 32'(em0.m));
`ifdef GATE_TT_FIRST_FAIL_EN
                chk("first_fail_vld0", 32'(ffv0), 32'(em0.fv));
                chk("first_fail_idx0", 32'(ffi0), 32'(em0.fi));
`endif
            end
        end
    end

    // One SETTLE=2 sweep: drv must hold each value 3 cycles, busy 12 cycles.
    task automatic sweep(input logic [3:0] e, input logic m, input logic fv, input logic [1:0] fi);
        int cyc;
        start    = 1'b1;
        expected = e;
        q.push_back('{tbl: 4'b1110, m: m, fv: fv, fi: fi});
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            chk("drv_step", 32'(drv), 32'(cyc / 3));
            @(negedge clk);
            cyc++;
        end
        chk("busy_cycles", 32'(cyc), 12);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; start0 = 1'b0; expected = '0; expected0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_drv", 32'(drv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_table", 32'(table_o), 0);
        chk("rst_match", 32'(match), 0);
        rst = 1'b0;
        @(negedge clk);

        // OR gate against OR table
        sweep(4'b1110, 1'b1, 1'b0, 2'd0);

        // Reset while vector 2 is applied: abandoned, no done pulse
        start    = 1'b1;
        expected = 4'b1110;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (drv != 2'd2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_vec2", 32'(drv), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_drv", 32'(drv), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_table", 32'(table_o), 0);
        chk("abort_match", 32'(match), 0);
        chk("abort_done", 32'(done), 0);
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 0);

        // Full sweep after the abort
        sweep(4'b1110, 1'b1, 1'b0, 2'd0);

        // OR gate against AND table: lowest mismatch at index 1
        sweep(4'b1000, 1'b0, 1'b1, 2'd1);

        // SETTLE=0: drv changes every cycle; expected changed mid-sweep is harmless
        start0    = 1'b1;
        expected0 = 4'b0000;
        q0.push_back('{tbl: 4'b1110, m: 1'b1, fv: 1'b0, fi: 2'd0});
        @(negedge clk);
        start0 = 1'b0;
        cyc    = 0;
        while (busy0 && cyc < 100) begin
            chk("drv0_step", 32'(drv0), 32'(cyc));
            if (cyc == 1) expected0 = 4'b1110;
            @(negedge clk);
            cyc++;
        end
        chk("busy0_cycles", 32'(cyc), 4);
        @(negedge clk);

        // start held high: ignored while busy, re-accepted in the done cycle
        start    = 1'b1;
        expected = 4'b1110;
        q.push_back('{tbl: 4'b1110, m: 1'b1, fv: 1'b0, fi: 2'd0});
        q.push_back('{tbl: 4'b1110, m: 1'b1, fv: 1'b0, fi: 2'd0});
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 100) begin
            chk("hold_drv_a", 32'(drv), 32'(cyc / 3));
            @(negedge clk);
            cyc++;
        end
        chk("hold_busy_a", 32'(cyc), 12);
        chk("hold_gap_low", 32'(busy), 0);
        @(negedge clk);
        chk("hold_restart_busy", 32'(busy), 1);
        chk("hold_restart_drv", 32'(drv), 0);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            chk("hold_drv_b", 32'(drv), 32'(cyc / 3));
            @(negedge clk);
            cyc++;
        end
        chk("hold_busy_b", 32'(cyc), 12);
        repeat (5) @(negedge clk);
        chk("no_third_sweep", 32'(busy), 0);

        chk("scoreboard_drained", 32'(q.size()), 0);
        chk("scoreboard0_drained", 32'(q0.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
